alu_iter_exec: RTL and testbench
================================

Name: alu_iter_exec

Overview:
- Execution unit on the consumer side of the 4-bit ALUControl interface produced by the ALU decoder.
- Accepts one operation per handshake (ALUControl, operand A, operand B) and returns a registered result, a zero flag and an illegal-op flag.
- Logic and arithmetic ops complete in 1 cycle. Shifts execute iteratively, 1 bit per cycle.
- Sits between operand select and writeback in the multi-cycle datapath variant.

Parameters:
- WIDTH, 32, operand/result width in bits; power of 2, at least 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- alu_control  input  4  operation code, encoding below.
- src_a  input  WIDTH  operand A.
- src_b  input  WIDTH  operand B; bits [SHW-1:0] are the shift amount for shifts.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  operation result.
- zero  output  1  result == 0.
- illegal  output  1  alu_control was not a defined code.

Behaviour:
- Encoding:
  - 0000 and, 0001 or, 0010 add, 0110 sub, 0100 xor
  - 0111 slt (signed), 1000 sltu
  - 1010 sll, 1011 srl, 1100 sra
  - all other codes (including 1111) illegal
- Reset (synchronous, wins over all other inputs): state=IDLE, in_ready=1, out_valid=0, result=0, zero=1, illegal=0, shift counter=0. Reset mid-shift or with out_valid held discards the operation with no output.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1. Accept on in_valid & in_ready; inputs are captured only on that edge.
  - Non-shift or illegal op: result register written; go to DONE.
  - Shift with shamt=0: result=src_a; go to DONE.
  - Shift with shamt>0: acc=src_a, count=shamt; go to SHIFT.
- SHIFT:
  - in_ready=0. Each cycle acc shifts by 1: sll inserts 0 at LSB; srl inserts 0 at MSB; sra replicates MSB. count decrements each cycle.
  - When count==1: perform the final shift, write result, go to DONE.
- DONE:
  - out_valid=1; result, zero and illegal held stable while out_ready=0.
  - On out_ready: go to IDLE, out_valid=0.
  - No new request is accepted in the same cycle; back-to-back throughput is 1 op per 2 cycles for single-cycle ops.
- Latency, with acceptance edge at cycle T:
  - Non-shift ops: out_valid high from T+1.
  - Shift by n: out_valid high from T+1+n. Maximum is T+WIDTH.
- Arithmetic rules:
  - add/sub wrap modulo 2^WIDTH; no carry or overflow output.
  - slt/sltu return 1 or 0 zero-extended to WIDTH.
  - Only src_b[SHW-1:0] is used as shamt; upper bits of src_b are ignored.
- Illegal op: result=0, zero=1, illegal=1, latency 1 cycle; the handshake completes normally.
- zero is computed from the final registered result. illegal is cleared by the next accepted legal op.
- in_valid while not in IDLE is ignored; the requester must hold the request until in_ready.
- in_ready and out_valid are never both high.

Test Plan:
- Reset, then add: src_a=0x00000005, src_b=0x00000003, code 0010 -> out_valid at T+1, result=0x00000008, zero=0, illegal=0.
- Sub giving zero: 0x7 - 0x7 (0110) -> result=0, zero=1. slt with 0xFFFFFFFF vs 0x1 -> result=1. sltu with the same operands -> result=0.
- sra: src_a=0x80000000, src_b=0x0000001F (shamt 31) -> out_valid exactly at T+32, result=0xFFFFFFFF. srl with the same operands -> 0x00000001. sll 0x1 by 0 -> 0x1 at T+1.
- Backpressure: complete an xor 0xF0F0F0F0 ^ 0x0F0F0F0F with out_ready=0 for 5 cycles -> result=0xFFFFFFFF held stable, in_ready=0 throughout. Assert out_ready -> IDLE next cycle.
- Illegal code 1111 and 0011 -> result=0, zero=1, illegal=1 at T+1. A following legal `or` clears illegal.
- Assert reset in the 3rd cycle of an sll by 10 -> next cycle out_valid=0, in_ready=1, result=0, and no result is ever presented for that op.

Source files
------------

// File: rtl/alu_iter_exec.sv
// alu_iter_exec: handshaked ALU with single-cycle logic/arith ops and 1-bit-per-cycle iterative shifts
module alu_iter_exec #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] result_q, acc, alu, step;
  logic [SHW-1:0] count;
  logic [1:0] sh_op;
  logic illegal_q, accept, is_shift, legal;
  logic [SHW-1:0] shamt;
  assign shamt = src_b[SHW-1:0];
  assign accept = in_valid && state == IDLE;
  assign is_shift = alu_control inside {4'b1010, 4'b1011, 4'b1100};
  assign legal = is_shift || alu_control inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0100, 4'b0111, 4'b1000};
  always_comb begin
    alu = '0;
    case (alu_control)
      4'b0000: alu = src_a & src_b;
      4'b0001: alu = src_a | src_b;
      4'b0010: alu = src_a + src_b;
      4'b0110: alu = src_a - src_b;
      4'b0100: alu = src_a ^ src_b;
      4'b0111: alu = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      4'b1000: alu = {{(WIDTH-1){1'b0}}, src_a < src_b};
      default: alu = '0;
    endcase
  end
  // sh_op holds alu_control[1:0]: 10 sll, 11 srl, 00 sra
  assign step = sh_op == 2'b10 ? acc << 1 : sh_op == 2'b11 ? acc >> 1 : {acc[WIDTH-1], acc[WIDTH-1:1]};
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? (is_shift && |shamt ? SHIFT : DONE) : IDLE;
      SHIFT:   state_n = count == SHW'(1) ? DONE : SHIFT;
      DONE:    state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
    result = result_q;
    zero = result_q == '0;
    illegal = illegal_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      illegal_q <= 1'b0;
      acc <= '0;
      count <= '0;
      sh_op <= '0;
    end else if (accept) begin
      illegal_q <= !legal;
      acc <= src_a;
      count <= shamt;
      sh_op <= alu_control[1:0];
      if (!(is_shift && |shamt)) result_q <= is_shift ? src_a : alu;
    end else if (state == SHIFT) begin
      acc <= step;
      count <= count - SHW'(1);
      if (count == SHW'(1)) result_q <= step;
    end
  end
endmodule

// File: tb/tb_alu_iter_exec.sv
// tb_alu_iter_exec: scoreboard bench comparing alu_iter_exec against a behavioural ALU model
module tb_alu_iter_exec;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, zero, illegal;
  logic [3:0] alu_control = '0;
  logic [31:0] src_a = '0, src_b = '0, result;
  logic [32:0] exp_q[$];
  int n_chk = 0, n_fail = 0;
  alu_iter_exec #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal(illegal)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [32:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] s;
    s = b[4:0];
    case (c)
      4'b0000: return {1'b0, a & b};
      4'b0001: return {1'b0, a | b};
      4'b0010: return {1'b0, a + b};
      4'b0110: return {1'b0, a - b};
      4'b0100: return {1'b0, a ^ b};
      4'b0111: return {1'b0, 31'd0, $signed(a) < $signed(b)};
      4'b1000: return {1'b0, 31'd0, a < b};
      4'b1010: return {1'b0, a << s};
      4'b1011: return {1'b0, a >> s};
      4'b1100: return {1'b0, $signed(a) >>> s};
      default: return {1'b1, 32'd0};
    endcase
  endfunction
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [32:0] e;
    logic [31:0] r0;
    int lat, exp_lat;
    exp_lat = (c inside {4'b1010, 4'b1011, 4'b1100}) ? 1 + int'(b[4:0]) : 1;
    exp_q.push_back(model(c, a, b));
    @(negedge clk);
    check("ready_before", in_ready, 1);
    alu_control = c; src_a = a; src_b = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    src_a = $urandom; src_b = $urandom; alu_control = 4'($urandom);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check($sformatf("latency_%b", c), lat, exp_lat);
    e = exp_q.pop_front();
    check($sformatf("result_%b", c), result, e[31:0]);
    check($sformatf("zero_%b", c), zero, e[31:0] == 0);
    check($sformatf("illegal_%b", c), illegal, e[32]);
    check("ready_in_done", in_ready, 0);
    r0 = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_result", result, r0);
      check("hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("done_valid_clear", out_valid, 0);
    check("done_ready_set", in_ready, 1);
  endtask
  initial begin
    int seen;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    check("rst_illegal", illegal, 0);
    run_op(4'b0010, 32'h5, 32'h3, 0);
    run_op(4'b0110, 32'h7, 32'h7, 0);
    run_op(4'b0111, 32'hFFFFFFFF, 32'h1, 0);
    run_op(4'b1000, 32'hFFFFFFFF, 32'h1, 0);
    run_op(4'b1100, 32'h80000000, 32'h1F, 0);
    run_op(4'b1011, 32'h80000000, 32'h1F, 0);
    run_op(4'b1010, 32'h1, 32'h0, 0);
    run_op(4'b1010, 32'h1, 32'hFFFFFF23, 0);
    run_op(4'b0100, 32'hF0F0F0F0, 32'h0F0F0F0F, 5);
    run_op(4'b1111, 32'h1234, 32'h5678, 0);
    run_op(4'b0011, 32'h1234, 32'h5678, 2);
    run_op(4'b0001, 32'h1, 32'h2, 0);
    run_op(4'b0000, 32'hFF00FF00, 32'h0FF00FF0, 0);
    for (int i = 0; i < 16; i++) run_op(4'($urandom), $urandom, $urandom, int'($urandom_range(0, 2)));
    @(negedge clk);
    alu_control = 4'b1010; src_a = 32'h3; src_b = 32'd10; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_valid", out_valid, 0);
    check("midrst_ready", in_ready, 1);
    check("midrst_result", result, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_no_output", seen, 0);
    run_op(4'b0010, 32'hFFFFFFFF, 32'h1, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
